// File: rtl/sp_ram_pkg.sv
// Shared constants and init-FSM encoding for the parametrised single-port RAM.
package sp_ram_pkg;

    localparam int RD_BYPASS  = 0;
    localparam int RD_PIPE    = 1;

    localparam int WR_NORMAL  = 0;
    localparam int WR_THROUGH = 1;
    localparam int WR_RBW     = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } init_state_e;

endpackage

// File: rtl/sp_ram_init_ctrl.sv
// Post-reset zero-fill sequencer: walks every address once, then releases busy.
module sp_ram_init_ctrl
    import sp_ram_pkg::*;
#(
    parameter int ADDR_W         = 9,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              busy_o
);

    init_state_e       state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            cnt_q   <= '0;
            busy_q  <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state_q)
                CLEAR: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    // Last address is written on this edge; access opens on the next one.
                    if (cnt_q == '1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: busy_q <= 1'b0;
            endcase
        end
    end

    assign clr_we_o   = (state_q == CLEAR);
    assign clr_addr_o = cnt_q;
    assign busy_o     = busy_q;

endmodule

// File: rtl/sp_ram_param.sv
// Single-port synchronous RAM with byte-lane writes, selectable write/read modes
// and an optional zero-fill sweep after reset.
module sp_ram_param
    import sp_ram_pkg::*;
#(
    parameter int  DATA_W         = 8,
    parameter int  ADDR_W         = 9,
    parameter int  BYTE_W         = 8,
    parameter int  READ_MODE      = 0,
    parameter int  WRITE_MODE     = 0,
    parameter int  CLEAR_ON_RESET = 1,
    localparam int NBE            = DATA_W / BYTE_W,
    localparam int DEPTH          = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              oce,
    input  logic              wre,
    input  logic [ADDR_W-1:0] ad,
    input  logic [DATA_W-1:0] din,
    input  logic [NBE-1:0]    be,
    output logic [DATA_W-1:0] dout,
    output logic              busy
);

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              acc;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged_word;
    logic [DATA_W-1:0] dstage_q;

    sp_ram_init_ctrl #(
        .ADDR_W        (ADDR_W),
        .CLEAR_ON_RESET(CLEAR_ON_RESET)
    ) u_init (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr_we_o  (clr_we),
        .clr_addr_o(clr_addr),
        .busy_o    (busy)
    );

    assign acc      = ce && !busy;
    assign old_word = mem[ad];

    for (genvar i = 0; i < NBE; i++) begin : g_lane
        assign merged_word[i*BYTE_W +: BYTE_W] = be[i] ? din[i*BYTE_W +: BYTE_W]
                                                       : old_word[i*BYTE_W +: BYTE_W];
    end

    // Array carries no reset so it maps onto block RAM; the sweep owns the port while busy.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (acc && wre) begin
            for (int i = 0; i < NBE; i++) begin
                if (be[i]) mem[ad][i*BYTE_W +: BYTE_W] <= din[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dstage_q <= '0;
        end else if (acc) begin
            if (!wre)                           dstage_q <= old_word;
            else if (WRITE_MODE == WR_THROUGH)  dstage_q <= merged_word;
            else if (WRITE_MODE == WR_RBW)      dstage_q <= old_word;
        end
    end

    if (READ_MODE == RD_PIPE) begin : g_pipe
        logic [DATA_W-1:0] pipe_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)  pipe_q <= '0;
            else if (oce)  pipe_q <= dstage_q;
        end
        assign dout = pipe_q;
    end else begin : g_bypass
        logic unused_oce;
        assign unused_oce = oce;
        assign dout       = dstage_q;
    end

endmodule

// File: doc/sp_ram_param.md
# sp_ram_param

Parametrised single-port synchronous RAM for the audio datapath: sample buffers, coefficient tables and scratch storage. It generalises the fixed 512x8 BSRAM wrapper with configurable width and depth, byte-lane write enables, three write modes, an optional output pipeline register and an optional zero-fill of the array after reset. It infers block RAM and sits between the stream controllers and any consumer that needs random access.

## Interface
- DATA_W, 8: word width in bits; must be a multiple of BYTE_W.
- ADDR_W, 9: address width; DEPTH = 2**ADDR_W.
- BYTE_W, 8: byte-lane width; NBE = DATA_W/BYTE_W.
- READ_MODE, 0: 0 = bypass (1-cycle read), 1 = pipeline (2-cycle read, output register gated by oce).
- WRITE_MODE, 0: 0 = normal (dout holds on write), 1 = write-through, 2 = read-before-write.
- CLEAR_ON_RESET, 1: 1 = zero-fill the whole array after reset release.
- clk  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ce  in  1  access enable; no read and no write when low.
- oce  in  1  output-register enable; pipeline mode only, ignored in bypass.
- wre  in  1  1 = write, 0 = read (qualified by ce).
- ad  in  ADDR_W  word address.
- din  in  DATA_W  write data.
- be  in  NBE  byte-lane write enables; bit i covers din[i*BYTE_W +: BYTE_W].
- dout  out  DATA_W  read data.
- busy  out  1  high while reset is active or the clear sweep runs; accesses are ignored while busy.

## Operation
- Init FSM states: CLEAR and IDLE.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
  - In CLEAR, a counter writes zero to one address per clock, 0 to DEPTH-1.
  - After the edge that writes DEPTH-1, the FSM moves to IDLE.
- busy is high in CLEAR, including the whole time reset_n is low; busy is low in IDLE.
- In IDLE, an access happens on each edge with ce=1.
  - Write (wre=1): only lanes with be[i]=1 are updated; other lanes keep their old contents. be=0 is a legal no-op write.
  - Read (wre=0): the array word at ad is loaded into the data stage.
- Data stage on a write, by WRITE_MODE:
  - 0: data stage holds its previous value.
  - 1: data stage loads the resulting stored word (old lanes merged with new lanes).
  - 2: data stage loads the word as it was before the write.
- ce=0 or busy=1: the array and the data stage both hold.
- Bypass mode: dout is the data stage.
- Pipeline mode: dout is a second register, loaded from the data stage on edges where oce=1, held otherwise.
- Out-of-range addresses are impossible: the array always has exactly DEPTH words.
- Reset mid-clear or mid-access: every register returns to its reset value and the sweep restarts at address 0. Contents already written are not guaranteed.

## Timing
- Reset values:
  - dout = 0.
  - busy = 1 if CLEAR_ON_RESET=1, else 0.
  - Data stage, pipeline register and clear counter = 0.
- Clear duration: busy falls DEPTH edges after reset_n rises (512 for the defaults). The first access is accepted on the next edge.
- Read latency, access issued on edge N:
  - Bypass: valid after edge N.
  - Pipeline: valid after edge N+1, provided oce=1 at N+1.
- Back-to-back accesses are accepted every cycle; throughput is one access per clock.
- Read-after-write to the same address on consecutive edges returns the new data.
- Write modes 1 and 2 report on dout with the same latency as a read.

## Structure
- Package sp_ram_pkg holds:
  - Constants RD_BYPASS=0 and RD_PIPE=1.
  - Constants WR_NORMAL=0, WR_THROUGH=1 and WR_RBW=2.
  - The FSM state enum and its CLEAR/IDLE encoding.
- Sub-module sp_ram_init_ctrl holds the clear FSM and the address counter. It drives the internal write port during CLEAR and drives busy.
- The top level does the port multiplexing, byte-lane merge, array inference, data stage and optional pipeline register.

## Test plan
- Defaults: release reset; count edges until busy=0 → exactly 512. Then read addresses 0, 255 and 511 → 0x00 each, one edge after issue.
- DATA_W=32, BYTE_W=8: write 0xAABBCCDD to address 5 with be=1111, then 0x11223344 with be=0101; read address 5 → 0xAA22CC44.
- WRITE_MODE=1, then WRITE_MODE=2: address 3 holds 0x5A; write 0xA5 to address 3 → dout=0xA5 in mode 1 and 0x5A in mode 2. In mode 0, dout keeps its previous value.
- READ_MODE=1: read address 7 holding 0x3C with oce=1 → dout=0x3C two edges after issue. Repeat with oce=0 on the second edge → dout holds its old value until an edge with oce=1.
- Pull reset_n low at sweep address 200, then release → dout=0 and busy=1 immediately; busy falls 512 edges after release. A write attempted while busy is ignored: the address still reads 0x00.
- ce=0 with wre=1 and be all-ones → array and dout unchanged. Back-to-back writes to addresses 0 through 9 then reads of 0 through 9 → data returned in order at one word per clock.
